sequenciador_banco: RTL

//  Command sequencer that owns the 3-register bank (A=0, B=1, Acumulador=2) and the ALU.
//  - Accepts one calculator command per valid/ready handshake.
//  - Drives the bank write/read controls and holds the ALU operands stable for the ALU latency.
//  - Writes the ALU result back to the Acumulador.
//  - Sits between the instruction decoder and the register bank + ALU.

---
 rtl/sequenciador_banco.sv | 106 ++++++++++
 1 files changed

// File: rtl/sequenciador_banco.sv
// Command sequencer for the A/B/Acumulador register bank and the ALU.
// Optional macro SEQ_CLEAR_CMD_EN enables Cmd=011 (clear Acumulador); otherwise 011 is illegal.
module sequenciador_banco #(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValido,
  output logic              CmdPronto,
  input  logic [2:0]        Cmd,
  input  logic [1:0]        CmdFonte,
  input  logic [2:0]        CmdOp,
  input  logic [DATA_W-1:0] CmdDado,
  output logic              Fim,
  output logic              Erro,
  output logic [1:0]        IdReg,
  output logic [1:0]        Fonte1,
  output logic [1:0]        Fonte2,
  output logic              Escrita,
  output logic              Flag_mem,
  output logic [DATA_W-1:0] Dado,
  output logic [2:0]        AluOp,
  input  logic [DATA_W-1:0] AluResultado
);

  localparam logic [2:0] C_LOAD_A = 3'b000;
  localparam logic [2:0] C_LOAD_B = 3'b001;
  localparam logic [2:0] C_EXEC   = 3'b010;
  localparam logic [2:0] C_CLEAR  = 3'b011;
  localparam logic [3:0] ESPERA_INI = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {OCIOSO, LEITURA, ESCRITA, FIM} estado_t;

  estado_t     state, state_n;
  logic [3:0]  espera;
  logic        aceita, ilegal;

  // Port 1 always reads the Acumulador in plain register mode.
  assign Fonte1   = 2'b10;
  assign Flag_mem = 1'b0;

  always_comb begin
    ilegal = Cmd[2];
`ifndef SEQ_CLEAR_CMD_EN
    if (Cmd == C_CLEAR) ilegal = 1'b1;
`endif
  end

  always_comb begin
    state_n   = state;
    CmdPronto = (state == OCIOSO);
    Escrita   = (state == ESCRITA);
    Fim       = (state == FIM);
    aceita    = CmdValido && (state == OCIOSO);
    case (state)
      OCIOSO: begin
        if (aceita && !ilegal) begin
          if (Cmd == C_EXEC) state_n = LEITURA;
          else               state_n = ESCRITA;
        end
      end
      LEITURA: if (espera == 4'd0) state_n = ESCRITA;
      ESCRITA: state_n = FIM;
      FIM:     state_n = OCIOSO;
      default: state_n = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= OCIOSO;
      Erro   <= 1'b0;
      IdReg  <= 2'd0;
      Fonte2 <= 2'd3;
      Dado   <= '0;
      AluOp  <= 3'd0;
      espera <= 4'd0;
    end else begin
      state <= state_n;
      Erro  <= aceita && ilegal;
      if (aceita && !ilegal) begin
        case (Cmd)
          C_LOAD_A: begin IdReg <= 2'd0; Dado <= CmdDado; end
          C_LOAD_B: begin IdReg <= 2'd1; Dado <= CmdDado; end
          C_EXEC: begin
            Fonte2 <= CmdFonte;
            AluOp  <= CmdOp;
            espera <= ESPERA_INI;
          end
          default: begin IdReg <= 2'd2; Dado <= '0; end
        endcase
      end
      // Operands have been stable ALU_LAT cycles when the counter reaches zero.
      if (state == LEITURA) begin
        if (espera == 4'd0) begin
          Dado  <= AluResultado;
          IdReg <= 2'd2;
        end else begin
          espera <= espera - 4'd1;
        end
      end
    end
  end

endmodule
